// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer: load-use bubbles, branch flushes and the data-memory req/ack wait with sticky timeout.
// Optional STALL_STATS_EN adds StallCycles/LoadUseCount counters.
module pipe_stall_ctrl #(
  parameter int unsigned DM_TIMEOUT = 255,
  parameter int unsigned CNT_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IFIDRs,
  input  logic [4:0]  IFIDRt,
  input  logic        IDEXMemRead,
  input  logic [4:0]  IDEXRt,
  input  logic        BranchTaken,
  input  logic        EXMEMMemRead,
  input  logic        EXMEMMemWrite,
  input  logic        dm_ack,
  output logic        dm_req,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        PipeHold,
  output logic        MEMWBBubble,
  output logic        dm_err
`ifdef STALL_STATS_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] LoadUseCount
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mem_op;
  logic             w_mem_stall;
  logic             w_load_use;

  assign w_mem_op   = EXMEMMemRead | EXMEMMemWrite;
  assign w_load_use = IDEXMemRead && (IDEXRt != 5'd0) &&
                      ((IDEXRt == IFIDRs) || (IDEXRt == IFIDRt));

  always_comb begin
    w_mem_stall = 1'b0;
    case (r_state)
      S_IDLE:  w_mem_stall = w_mem_op & ~dm_ack;
      S_WAIT:  w_mem_stall = ~dm_ack;
      S_ERR:   w_mem_stall = 1'b1;
      default: w_mem_stall = 1'b0;
    endcase
  end

  // Outputs are forced low while rst is held, even though state is already IDLE.
  always_comb begin
    dm_req      = 1'b0;
    PCWrite     = 1'b0;
    IFIDWrite   = 1'b0;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    PipeHold    = 1'b0;
    MEMWBBubble = 1'b0;
    dm_err      = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:  dm_req = w_mem_op;
        S_WAIT:  dm_req = 1'b1;
        default: dm_req = 1'b0;
      endcase
      if (r_state == S_ERR) begin
        PipeHold    = 1'b1;
        MEMWBBubble = 1'b1;
        dm_err      = 1'b1;
      end else if (w_mem_stall) begin
        PipeHold    = 1'b1;
        MEMWBBubble = 1'b1;
      end else if (w_load_use) begin
        IDEXFlush   = 1'b1;
      end else if (BranchTaken) begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b1;
      end else begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op && !dm_ack) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (dm_ack) begin
            r_state <= S_IDLE;
          end else begin
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DM_TIMEOUT)) r_state <= S_ERR;
          end
        end
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_load_use_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles   <= '0;
      r_load_use_count <= '0;
    end else begin
      if (w_mem_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (!w_mem_stall && w_load_use) r_load_use_count <= r_load_use_count + 32'd1;
    end
  end

  assign StallCycles  = r_stall_cycles;
  assign LoadUseCount = r_load_use_count;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (DM_TIMEOUT=4); output vector order:
// {dm_req, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, PipeHold, MEMWBBubble, dm_err}.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IFIDRs, IFIDRt, IDEXRt;
  logic       IDEXMemRead, BranchTaken, EXMEMMemRead, EXMEMMemWrite, dm_ack;
  logic       dm_req, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, PipeHold, MEMWBBubble, dm_err;
`ifdef STALL_STATS_EN
  logic [31:0] StallCycles, LoadUseCount;
`endif
  logic [7:0] obs;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] E_ZERO   = 8'b0000_0000;
  localparam logic [7:0] E_NORM   = 8'b0110_0000;
  localparam logic [7:0] E_ACC    = 8'b1110_0000;
  localparam logic [7:0] E_MSTALL = 8'b1000_0110;
  localparam logic [7:0] E_ERR    = 8'b0000_0111;
  localparam logic [7:0] E_LU     = 8'b0000_1000;
  localparam logic [7:0] E_BR     = 8'b0111_0000;

  pipe_stall_ctrl #(.DM_TIMEOUT(4), .CNT_W(10)) dut (
    .clk(clk), .rst(rst),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt),
    .IDEXMemRead(IDEXMemRead), .IDEXRt(IDEXRt),
    .BranchTaken(BranchTaken),
    .EXMEMMemRead(EXMEMMemRead), .EXMEMMemWrite(EXMEMMemWrite),
    .dm_ack(dm_ack), .dm_req(dm_req),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .PipeHold(PipeHold), .MEMWBBubble(MEMWBBubble), .dm_err(dm_err)
`ifdef STALL_STATS_EN
    , .StallCycles(StallCycles), .LoadUseCount(LoadUseCount)
`endif
  );

  assign obs = {dm_req, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, PipeHold, MEMWBBubble, dm_err};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    IFIDRs = 5'd0; IFIDRt = 5'd0; IDEXRt = 5'd0;
    IDEXMemRead = 1'b0; BranchTaken = 1'b0;
    EXMEMMemRead = 1'b0; EXMEMMemWrite = 1'b0; dm_ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    total++; if (obs !== E_ZERO) begin bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, E_ZERO); end
`ifdef STALL_STATS_EN
    total++; if (StallCycles !== 32'd0 || LoadUseCount !== 32'd0) begin bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", StallCycles, LoadUseCount); end
`endif
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    total++; if (obs !== E_NORM) begin bad++; $display("FAIL after_reset_normal got=%b exp=%b", obs, E_NORM); end
  endtask

  task automatic test_zero_wait();
    cyc(); EXMEMMemRead = 1'b1; dm_ack = 1'b1;
    @(negedge clk);
    total++; if (obs !== E_ACC) begin bad++; $display("FAIL zero_wait_lw got=%b exp=%b", obs, E_ACC); end
    cyc(); EXMEMMemRead = 1'b0; dm_ack = 1'b0;
    @(negedge clk);
    total++; if (obs !== E_NORM) begin bad++; $display("FAIL zero_wait_idle got=%b exp=%b", obs, E_NORM); end
  endtask

  task automatic test_mem_stall();
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(); EXMEMMemWrite = 1'b1; dm_ack = 1'b0;
      @(negedge clk);
      total++; if (obs !== E_MSTALL) begin bad++; $display("FAIL sw_stall_%0d got=%b exp=%b", i, obs, E_MSTALL); end
    end
    cyc(); dm_ack = 1'b1;
    @(negedge clk);
    total++; if (obs !== E_ACC) begin bad++; $display("FAIL sw_ack_advance got=%b exp=%b", obs, E_ACC); end
    cyc(); EXMEMMemWrite = 1'b0; dm_ack = 1'b0;
    @(negedge clk);
    total++; if (obs !== E_NORM) begin bad++; $display("FAIL sw_back_idle got=%b exp=%b", obs, E_NORM); end
  endtask

  task automatic test_load_use();
    cyc(); IDEXMemRead = 1'b1; IDEXRt = 5'd5; IFIDRs = 5'd5; IFIDRt = 5'd9;
    @(negedge clk);
    total++; if (obs !== E_LU) begin bad++; $display("FAIL lu_rs got=%b exp=%b", obs, E_LU); end
    cyc(); IFIDRs = 5'd3; IFIDRt = 5'd5;
    @(negedge clk);
    total++; if (obs !== E_LU) begin bad++; $display("FAIL lu_rt got=%b exp=%b", obs, E_LU); end
    cyc(); IDEXRt = 5'd0; IFIDRs = 5'd0; IFIDRt = 5'd0;
    @(negedge clk);
    total++; if (obs !== E_NORM) begin bad++; $display("FAIL lu_r0 got=%b exp=%b", obs, E_NORM); end
    cyc(); IDEXRt = 5'd7; IFIDRs = 5'd6; IFIDRt = 5'd8;
    @(negedge clk);
    total++; if (obs !== E_NORM) begin bad++; $display("FAIL lu_nomatch got=%b exp=%b", obs, E_NORM); end
    cyc(); IDEXMemRead = 1'b0; IDEXRt = 5'd6;
    @(negedge clk);
    total++; if (obs !== E_NORM) begin bad++; $display("FAIL lu_not_load got=%b exp=%b", obs, E_NORM); end
    cyc(); clear_inputs();
  endtask

  task automatic test_priority();
    cyc(); IDEXMemRead = 1'b1; IDEXRt = 5'd4; IFIDRs = 5'd4; BranchTaken = 1'b1;
    @(negedge clk);
    total++; if (obs !== E_LU) begin bad++; $display("FAIL lu_over_branch got=%b exp=%b", obs, E_LU); end
    cyc(); IDEXMemRead = 1'b0;
    @(negedge clk);
    total++; if (obs !== E_BR) begin bad++; $display("FAIL branch_alone got=%b exp=%b", obs, E_BR); end
    cyc(); IDEXMemRead = 1'b1; EXMEMMemRead = 1'b1; dm_ack = 1'b0;
    @(negedge clk);
    total++; if (obs !== E_MSTALL) begin bad++; $display("FAIL mem_over_lu got=%b exp=%b", obs, E_MSTALL); end
    cyc(); dm_ack = 1'b1;
    @(negedge clk);
    total++; if (obs !== 8'b1000_1000) begin bad++; $display("FAIL ack_then_lu got=%b exp=%b", obs, 8'b1000_1000); end
    cyc(); clear_inputs(); dm_ack = 1'b1;
    @(negedge clk);
    total++; if (obs !== E_NORM) begin bad++; $display("FAIL ack_ignored_idle got=%b exp=%b", obs, E_NORM); end
    cyc(); dm_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    cyc(); EXMEMMemRead = 1'b1; dm_ack = 1'b1;
    @(negedge clk);
    total++; if (obs !== E_ACC) begin bad++; $display("FAIL b2b_rd got=%b exp=%b", obs, E_ACC); end
    cyc(); EXMEMMemRead = 1'b0; EXMEMMemWrite = 1'b1;
    @(negedge clk);
    total++; if (obs !== E_ACC) begin bad++; $display("FAIL b2b_wr got=%b exp=%b", obs, E_ACC); end
    cyc(); EXMEMMemWrite = 1'b0; EXMEMMemRead = 1'b1; dm_ack = 1'b0;
    @(negedge clk);
    total++; if (obs !== E_MSTALL) begin bad++; $display("FAIL b2b_stall got=%b exp=%b", obs, E_MSTALL); end
    cyc(); dm_ack = 1'b1;
    @(negedge clk);
    total++; if (obs !== E_ACC) begin bad++; $display("FAIL b2b_wait_ack got=%b exp=%b", obs, E_ACC); end
    cyc(); clear_inputs();
  endtask

  task automatic test_timeout();
    cyc(); EXMEMMemRead = 1'b1; dm_ack = 1'b0;
    @(negedge clk);
    total++; if (obs !== E_MSTALL) begin bad++; $display("FAIL to_idle_stall got=%b exp=%b", obs, E_MSTALL); end
    for (int unsigned i = 1; i <= 4; i++) begin
      cyc();
      @(negedge clk);
      total++; if (obs !== E_MSTALL) begin bad++; $display("FAIL to_wait_%0d got=%b exp=%b", i, obs, E_MSTALL); end
    end
    cyc();
    @(negedge clk);
    total++; if (obs !== E_ERR) begin bad++; $display("FAIL to_err got=%b exp=%b", obs, E_ERR); end
    cyc(); dm_ack = 1'b1; BranchTaken = 1'b1;
    @(negedge clk);
    total++; if (obs !== E_ERR) begin bad++; $display("FAIL err_holds got=%b exp=%b", obs, E_ERR); end
    cyc(); rst = 1'b1;
    #1;
    total++; if (obs !== E_ZERO) begin bad++; $display("FAIL err_rst got=%b exp=%b", obs, E_ZERO); end
    clear_inputs();
    cyc(); rst = 1'b0;
    @(negedge clk);
    total++; if (obs !== E_NORM) begin bad++; $display("FAIL err_cleared got=%b exp=%b", obs, E_NORM); end
  endtask

  task automatic test_reset_mid_wait();
    cyc(); EXMEMMemWrite = 1'b1; dm_ack = 1'b0;
    cyc();
    @(negedge clk);
    total++; if (obs !== E_MSTALL) begin bad++; $display("FAIL mw_in_wait got=%b exp=%b", obs, E_MSTALL); end
    cyc(); #2; rst = 1'b1;
    #1;
    total++; if (obs !== E_ZERO) begin bad++; $display("FAIL mw_rst_drop got=%b exp=%b", obs, E_ZERO); end
    EXMEMMemWrite = 1'b0;
    cyc(); rst = 1'b0;
    @(negedge clk);
    total++; if (obs !== E_NORM) begin bad++; $display("FAIL mw_after_rst got=%b exp=%b", obs, E_NORM); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_mem_stall();
    test_load_use();
    test_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
